// File: rtl/theta_pkg.sv
// Shared types and constants for the theta tracker slice.
package theta_pkg;

  // Tracker FSM: wait for the first index, measure one full revolution,
  // wait for the first slice length, then follow the rotor.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARM   = 2'd1,
    DIV   = 2'd2,
    TRACK = 2'd3
  } theta_state_t;

  // Flops between the raw hall input and the edge detector.
  localparam int SYNC_STAGES = 2;

endpackage

// File: rtl/seq_divider.sv
// Restoring unsigned divider producing one quotient bit per clock.
// A start loads the operands; done pulses W+1 cycles after start.
// start restarts an operation already in flight; abort drops it silently.
module seq_divider
  import theta_pkg::*;
#(
  parameter int W = 24
) (
  input  logic         clk_in,
  input  logic         rst_n_in,
  input  logic         start,
  input  logic         abort,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int SW = $clog2(W + 1);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  logic          busy;
  logic [SW-1:0] step_cnt;
  logic [W-1:0]  rem;
  logic [W-1:0]  quo;
  logic [W:0]    shifted;
  logic [W-1:0]  diff;
  logic          fits;

  // The partial remainder always stays below the divisor, so after the
  // subtraction the low W bits hold the full result.
  assign shifted  = {rem, quo[W-1]};
  assign fits     = (shifted >= {1'b0, divisor});
  assign diff     = shifted[W-1:0] - divisor;
  assign quotient = quo;

  // Load on start, then shift in one quotient bit per cycle until done.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy     <= 1'b0;
      step_cnt <= '0;
      rem      <= '0;
      quo      <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (abort) begin
        busy <= 1'b0;
      end else if (start) begin
        busy     <= 1'b1;
        step_cnt <= '0;
        rem      <= '0;
        quo      <= dividend;
      end else if (busy) begin
        rem      <= fits ? diff : shifted[W-1:0];
        quo      <= {quo[W-2:0], fits};
        step_cnt <= step_cnt + 1'b1;
        if (step_cnt == LAST_STEP) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/theta_tracker.sv
// Turns the once-per-revolution hall index into an evenly stepped angular
// slice index. Each revolution is timed in clock cycles, divided by the
// number of slices, and theta advances once per resulting slice length.
module theta_tracker
  import theta_pkg::*;
#(
  parameter int ROTATIONAL_RES = 180,
  parameter int THETA_RES      = 8,
  parameter int PERIOD_W       = 24,
  parameter int LOCKOUT        = 1000
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 hall_in,
  output logic [THETA_RES-1:0] theta,
  output logic                 theta_strobe,
  output logic                 theta_valid,
  output logic [PERIOD_W-1:0]  period_out
);

  localparam logic [PERIOD_W-1:0]  PER_MAX   = '1;
  localparam logic [PERIOD_W-1:0]  PER_ONE   = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0]  RES_DIV   = PERIOD_W'(ROTATIONAL_RES);
  localparam logic [THETA_RES-1:0] THETA_MAX = THETA_RES'(ROTATIONAL_RES - 1);
  localparam int                   LOCK_W    = $clog2(LOCKOUT + 1);
  localparam logic [LOCK_W-1:0]    LOCK_LOAD = LOCK_W'(LOCKOUT);

  logic [SYNC_STAGES-1:0] hall_sync;
  logic                   hall_prev;
  logic                   hall_fall;
  logic                   idx;
  logic [LOCK_W-1:0]      lock_cnt;
  logic [PERIOD_W-1:0]    per_cnt;
  logic                   timeout;
  logic                   div_start;
  logic                   div_done;
  logic [PERIOD_W-1:0]    div_quot;
  logic [PERIOD_W-1:0]    slice_len;
  logic [PERIOD_W-1:0]    slice_cnt;
  theta_state_t           state;

  assign hall_fall   = hall_prev & ~hall_sync[SYNC_STAGES-1];
  assign timeout     = (state != IDLE) && (per_cnt == PER_MAX);
  assign theta_valid = (state == TRACK);

  // Synchronise the hall input and register the index pulse; the sensor
  // idles high, so the sync chain resets high to avoid a false edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hall_sync <= '1;
      hall_prev <= 1'b1;
      idx       <= 1'b0;
    end else begin
      hall_sync <= {hall_sync[SYNC_STAGES-2:0], hall_in};
      hall_prev <= hall_sync[SYNC_STAGES-1];
      idx       <= hall_fall && (lock_cnt == '0);
    end
  end

  // Blank further edges for a while after each accepted index (sensor bounce).
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      lock_cnt <= '0;
    end else if (idx) begin
      lock_cnt <= LOCK_LOAD;
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - 1'b1;
    end
  end

  // Time the revolution; the counter saturates so a stalled rotor reads as timeout.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      per_cnt    <= '0;
      period_out <= '0;
    end else if (idx) begin
      per_cnt    <= PER_ONE;
      period_out <= per_cnt;
    end else if (per_cnt != PER_MAX) begin
      per_cnt <= per_cnt + 1'b1;
    end
  end

  // Kick the divider the cycle after a meaningful period has been latched.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      div_start <= 1'b0;
    end else begin
      div_start <= idx && (state != IDLE) && !timeout;
    end
  end

  seq_divider #(
    .W(PERIOD_W)
  ) u_div (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .start    (div_start),
    .abort    (timeout),
    .dividend (period_out),
    .divisor  (RES_DIV),
    .quotient (div_quot),
    .done     (div_done)
  );

  // Tracker state and slice length; a zero quotient would stall theta, so clamp to 1.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      slice_len <= PER_ONE;
    end else if (timeout) begin
      state     <= IDLE;
      slice_len <= PER_ONE;
    end else begin
      case (state)
        IDLE:    if (idx) state <= ARM;
        ARM:     if (idx) state <= DIV;
        DIV:     if (div_done) state <= TRACK;
        default: state <= TRACK;
      endcase
      if (div_done && (state != IDLE)) begin
        slice_len <= (div_quot == '0) ? PER_ONE : div_quot;
      end
    end
  end

  // Step theta once per slice; an index restarts the revolution and wins over a step.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      theta        <= '0;
      slice_cnt    <= '0;
      theta_strobe <= 1'b0;
    end else begin
      theta_strobe <= 1'b0;
      if (timeout) begin
        theta     <= '0;
        slice_cnt <= '0;
      end else if (state != IDLE) begin
        if (idx) begin
          theta        <= '0;
          slice_cnt    <= '0;
          theta_strobe <= 1'b1;
        end else if (slice_cnt >= slice_len - 1'b1) begin
          slice_cnt <= '0;
          if (theta != THETA_MAX) begin
            theta        <= theta + 1'b1;
            theta_strobe <= 1'b1;
          end
        end else begin
          slice_cnt <= slice_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_theta_tracker.sv
// Scoreboard bench for theta_tracker. Stimulus pushes the expected strobe
// sequence (theta, period at the index strobe, spacing since the previous
// strobe) and a monitor pops one entry per theta_strobe. A 12-bit period
// counter keeps the stall timeout reachable in a short run; a second
// instance with a short lockout covers revolutions shorter than the slice count.
module tb_theta_tracker;

  localparam int PW = 12;

  typedef struct {
    int theta;
    int period;
    int gap;
  } sb_entry_t;

  logic          clk_in = 1'b0;
  logic          rst_n_in;
  logic          hall_in;
  logic          hall2_in;
  logic [7:0]    theta;
  logic          theta_strobe;
  logic          theta_valid;
  logic [PW-1:0] period_out;
  logic [7:0]    theta2;
  logic          theta2_strobe;
  logic          theta2_valid;
  logic [PW-1:0] period2_out;

  sb_entry_t sb_queue[$];
  sb_entry_t mon_entry;
  int        check_count = 0;
  int        error_count = 0;
  int        cyc = 0;
  int        last_strobe_cyc = 0;

  theta_tracker #(
    .PERIOD_W(PW)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .hall_in      (hall_in),
    .theta        (theta),
    .theta_strobe (theta_strobe),
    .theta_valid  (theta_valid),
    .period_out   (period_out)
  );

  theta_tracker #(
    .PERIOD_W(PW),
    .LOCKOUT (50)
  ) dut_fast (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .hall_in      (hall2_in),
    .theta        (theta2),
    .theta_strobe (theta2_strobe),
    .theta_valid  (theta2_valid),
    .period_out   (period2_out)
  );

  // 100 MHz clock.
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string name, input int actual, input int expected);
    check_count++;
    if (actual != expected) begin
      error_count++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  function automatic void pushEntry(input int th, input int per, input int gap);
    sb_entry_t e;
    e.theta  = th;
    e.period = per;
    e.gap    = gap;
    sb_queue.push_back(e);
  endfunction

  function automatic void pushZero(input int per);
    pushEntry(0, per, 0);
  endfunction

  function automatic void pushRamp(input int first, input int last, input int gap_first,
                                   input int gap_rest);
    for (int t = first; t <= last; t++) begin
      pushEntry(t, -1, (t == first) ? gap_first : gap_rest);
    end
  endfunction

  // Drop the hall line at this negedge, release it 4 cycles later, and
  // advance gap cycles so consecutive calls space falling edges exactly.
  task automatic applyStimulus(input int gap, input bit second);
    if (second) hall2_in = 1'b0;
    else        hall_in  = 1'b0;
    fork
      begin
        repeat (4) @(negedge clk_in);
        if (second) hall2_in = 1'b1;
        else        hall_in  = 1'b1;
      end
    join_none
    repeat (gap) @(negedge clk_in);
  endtask

  // Monitor: every strobe of the main instance consumes one scoreboard entry.
  always @(negedge clk_in) begin
    cyc++;
    if (rst_n_in && theta_strobe) begin
      if (sb_queue.size() == 0) begin
        check_count++;
        error_count++;
        $display("[TB] FAIL sb_unexpected: got strobe with theta %0d, expected no strobe", theta);
      end else begin
        mon_entry = sb_queue.pop_front();
        checkOutput("sb_theta", int'(theta), mon_entry.theta);
        if (mon_entry.period >= 0) checkOutput("sb_period", int'(period_out), mon_entry.period);
        if (mon_entry.gap > 0) checkOutput("sb_gap", cyc - last_strobe_cyc, mon_entry.gap);
      end
      last_strobe_cyc = cyc;
    end
  end

  // Watchdog so the run always ends.
  initial begin
    repeat (60000) @(posedge clk_in);
    check_count++;
    error_count++;
    $display("[TB] FAIL watchdog: got no end of test, expected finish within 60000 cycles");
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $fatal(1, "[TB] cycle budget exhausted");
  end

  // Directed sequence.
  initial begin
    rst_n_in = 1'b0;
    hall_in  = 1'b1;
    hall2_in = 1'b1;

    $display("[TB] reset held while hall toggles");
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_in);
      hall_in  = ~hall_in;
      hall2_in = ~hall2_in;
      checkOutput("rst_theta", int'(theta), 0);
      checkOutput("rst_strobe", int'(theta_strobe), 0);
      checkOutput("rst_valid", int'(theta_valid), 0);
      checkOutput("rst_period", int'(period_out), 0);
    end
    hall_in  = 1'b1;
    hall2_in = 1'b1;
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (5) @(negedge clk_in);
    checkOutput("idle_valid", int'(theta_valid), 0);
    checkOutput("idle_theta", int'(theta), 0);

    $display("[TB] lock at 1800-cycle revolutions");
    pushRamp(1, 179, 0, 1);
    applyStimulus(1800, 1'b0);
    pushZero(1800);
    pushRamp(1, 14, 1, 1);
    pushRamp(15, 179, 10, 10);
    fork
      begin
        repeat (17) @(negedge clk_in);
        checkOutput("lock_valid_pre", int'(theta_valid), 0);
        @(negedge clk_in);
        checkOutput("lock_valid_post", int'(theta_valid), 1);
      end
    join_none
    applyStimulus(1800, 1'b0);
    pushZero(1800);
    pushRamp(1, 179, 10, 10);

    $display("[TB] slowdown to 2400 cycles");
    fork
      begin
        repeat (2300) @(negedge clk_in);
        checkOutput("slow_hold_theta", int'(theta), 179);
        checkOutput("slow_hold_strobe", int'(theta_strobe), 0);
      end
    join_none
    applyStimulus(2400, 1'b0);
    pushZero(2400);
    pushRamp(1, 1, 10, 10);
    pushRamp(2, 92, 13, 13);

    $display("[TB] glitch inside lockout, then speedup to 1200 cycles");
    applyStimulus(500, 1'b0);
    applyStimulus(700, 1'b0);
    pushZero(1200);
    pushRamp(1, 1, 13, 13);
    pushRamp(2, 179, 6, 6);

    $display("[TB] hall stops, expect timeout");
    fork
      begin
        repeat (4098) @(negedge clk_in);
        checkOutput("tmo_valid_pre", int'(theta_valid), 1);
        checkOutput("tmo_theta_pre", int'(theta), 179);
        @(negedge clk_in);
        checkOutput("tmo_valid_post", int'(theta_valid), 0);
        checkOutput("tmo_theta_post", int'(theta), 0);
        checkOutput("tmo_strobe_post", int'(theta_strobe), 0);
      end
    join_none
    applyStimulus(4200, 1'b0);

    $display("[TB] re-lock after timeout");
    pushRamp(1, 179, 0, 1);
    fork
      begin
        repeat (4) @(negedge clk_in);
        checkOutput("relock_period_sat", int'(period_out), 4095);
        checkOutput("relock_valid_arm", int'(theta_valid), 0);
      end
    join_none
    applyStimulus(1800, 1'b0);
    pushZero(1800);
    pushRamp(1, 14, 1, 1);
    pushRamp(15, 179, 10, 10);
    fork
      begin
        repeat (17) @(negedge clk_in);
        checkOutput("relock_valid_pre", int'(theta_valid), 0);
        @(negedge clk_in);
        checkOutput("relock_valid_post", int'(theta_valid), 1);
      end
    join_none
    applyStimulus(1800, 1'b0);

    $display("[TB] reset five cycles into a divide");
    pushZero(1800);
    applyStimulus(9, 1'b0);
    rst_n_in = 1'b0;
    #1;
    checkOutput("midrst_theta", int'(theta), 0);
    checkOutput("midrst_strobe", int'(theta_strobe), 0);
    checkOutput("midrst_valid", int'(theta_valid), 0);
    checkOutput("midrst_period", int'(period_out), 0);
    repeat (3) @(negedge clk_in);
    rst_n_in = 1'b1;
    repeat (40) @(negedge clk_in);
    checkOutput("postrst_valid", int'(theta_valid), 0);
    checkOutput("postrst_period", int'(period_out), 0);
    checkOutput("postrst_theta", int'(theta), 0);

    $display("[TB] 100-cycle revolution on short-lockout instance");
    applyStimulus(100, 1'b1);
    fork
      begin
        repeat (4) @(negedge clk_in);
        checkOutput("fast_theta_idx", int'(theta2), 0);
        checkOutput("fast_strobe_idx", int'(theta2_strobe), 1);
        checkOutput("fast_period", int'(period2_out), 100);
        repeat (14) @(negedge clk_in);
        checkOutput("fast_valid", int'(theta2_valid), 1);
        repeat (35) @(negedge clk_in);
        checkOutput("fast_theta_49", int'(theta2), 49);
        repeat (130) @(negedge clk_in);
        checkOutput("fast_theta_179", int'(theta2), 179);
        repeat (120) @(negedge clk_in);
        checkOutput("fast_theta_sat", int'(theta2), 179);
        checkOutput("fast_strobe_sat", int'(theta2_strobe), 0);
      end
    join_none
    applyStimulus(310, 1'b1);

    checkOutput("sb_drained", sb_queue.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
